// File: rtl/gray_convert_arbiter.sv
// gray_convert_arbiter
//
// Two-requester round-robin front end for one shared bit-serial
// Gray-to-binary converter. A granted Gray word is shadowed, then the XOR
// chain is walked MSB-first, one bit per clock. The finished binary word is
// presented with a one-cycle valid strobe and the owning requester's ID.
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      synchronous active-low reset
//   req0/req1  level requests, held until the matching grant
//   gray0/1    Gray words, stable while the matching req is high
//   gnt0/gnt1  one-cycle capture pulses, never high together
//   bin_out    last completed binary result, held between completions
//   bin_valid  one-cycle pulse when bin_out/bin_id update
//   bin_id     requester that owns bin_out
//   busy       high while a conversion is in flight
module gray_convert_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] gray0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] gray1,
    output logic             gnt1,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             bin_id,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CONVERT = 1'b1;

    logic [0:0]       state_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] b_r;
    logic [IDX_W-1:0] idx_r;
    logic             id_r;
    logic             prio_r;

    logic [WIDTH-1:0] b_above_s;
    logic             next_bit_s;
    logic             pick1_s;
    logic             any_req_s;
    logic [WIDTH-1:0] result_s;

    // One step of the XOR prefix chain: the top bit copies the Gray bit,
    // every lower bit folds in the already-computed binary bit above it.
    function automatic logic xor_step(input logic is_top,
                                      input logic b_above,
                                      input logic g_bit);
        return is_top ? g_bit : (b_above ^ g_bit);
    endfunction

    // Next result bit, arbitration choice and the assembled final word.
    always_comb begin
        // bit i of b_above_s holds b_r[i+1], so idx_r never indexes past MSB
        b_above_s  = {1'b0, b_r[WIDTH-1:1]};
        next_bit_s = xor_step(idx_r == IDX_TOP, b_above_s[idx_r], g_r[idx_r]);
        any_req_s  = req0 | req1;
        if (req0 && req1) begin
            pick1_s = prio_r;
        end else begin
            pick1_s = req1;
        end
        // only meaningful on the idx_r == 0 cycle, where bit 0 is the new bit
        result_s = {b_r[WIDTH-1:1], next_bit_s};
    end

    // Arbiter/converter state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            g_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            idx_r     <= IDX_ZERO;
            id_r      <= 1'b0;
            prio_r    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            bin_out   <= {WIDTH{1'b0}};
            bin_valid <= 1'b0;
            bin_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            bin_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r <= ST_CONVERT;
                        busy    <= 1'b1;
                        idx_r   <= IDX_TOP;
                        id_r    <= pick1_s;
                        // the loser of this grant gets priority next time
                        prio_r  <= ~pick1_s;
                        if (pick1_s) begin
                            g_r  <= gray1;
                            gnt1 <= 1'b1;
                        end else begin
                            g_r  <= gray0;
                            gnt0 <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    b_r[idx_r] <= next_bit_s;
                    if (idx_r == IDX_ZERO) begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        bin_out   <= result_s;
                        bin_id    <= id_r;
                        bin_valid <= 1'b1;
                    end else begin
                        idx_r <= idx_r - IDX_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_convert_arbiter.sv
// Scoreboard bench for gray_convert_arbiter. A transaction-level model
// (round-robin choice, fixed conversion occupancy, arithmetic Gray decode)
// predicts grants and pushes expected results; a separate monitor pops them
// when bin_valid appears and checks value, owner and arrival cycle.
module tb_gray_convert_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [WIDTH-1:0] gray0, gray1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic             bin_id;
    logic             busy;

    gray_convert_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .gray0     (gray0),
        .gnt0      (gnt0),
        .req1      (req1),
        .gray1     (gray1),
        .gnt1      (gnt1),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .bin_id    (bin_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic             id;
        int               due;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] gq0[$];
    logic [WIDTH-1:0] gq1[$];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   m_left = 0;
    logic m_prio = 1'b0;
    logic m_reset_edge = 1'b1;
    logic exp_g0 = 1'b0;
    logic exp_g1 = 1'b0;
    bit   rnd_gap = 1'b0;

    logic [WIDTH-1:0] held_bin = '0;
    logic             held_id = 1'b0;

    // binary bit i is the XOR of all Gray bits at i and above
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // One clock: model the edge that just happened, check grants/busy,
    // then let the requesters react.
    task automatic step();
        logic sel;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (!rst_n) begin
            m_left = 0;
            m_prio = 1'b0;
            sb_q.delete();
            m_reset_edge = 1'b1;
        end else begin
            m_reset_edge = 1'b0;
            if (m_left > 0) begin
                m_left--;
            end else if (req0 || req1) begin
                sel   = (req0 && req1) ? m_prio : req1;
                e.bin = gray2bin(sel ? gray1 : gray0);
                e.id  = sel;
                e.due = cyc + WIDTH;
                sb_q.push_back(e);
                m_left = WIDTH;
                m_prio = ~sel;
                if (sel) exp_g1 = 1'b1;
                else     exp_g0 = 1'b1;
            end
        end
        chk("gnt0", 32'(gnt0), 32'(exp_g0));
        chk("gnt1", 32'(gnt1), 32'(exp_g1));
        chk("busy", 32'(busy), 32'(m_left != 0));

        if (exp_g0) req0 = 1'b0;
        else if (!req0 && gq0.size() > 0 && (!rnd_gap || $urandom_range(2, 0) != 0)) begin
            gray0 = gq0.pop_front();
            req0  = 1'b1;
        end
        if (exp_g1) req1 = 1'b0;
        else if (!req1 && gq1.size() > 0 && (!rnd_gap || $urandom_range(2, 0) != 0)) begin
            gray1 = gq1.pop_front();
            req1  = 1'b1;
        end
    endtask

    function automatic bit all_idle();
        return (m_left == 0) && (sb_q.size() == 0) && (gq0.size() == 0) &&
               (gq1.size() == 0) && !req0 && !req1;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (!all_idle() && i < max_cyc);
        n_vec++;
        if (!all_idle()) begin
            n_miss++;
            $display("FAIL idle_timeout at cycle %0d: got busy after %0d cycles expected idle", cyc, i);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on bin_valid, otherwise checks hold.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (m_reset_edge) begin
            chk("rst_bin_valid", 32'(bin_valid), 32'd0);
            chk("rst_bin_out", 32'(bin_out), 32'd0);
            chk("rst_bin_id", 32'(bin_id), 32'd0);
            held_bin = '0;
            held_id  = 1'b0;
        end else if (bin_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(bin_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("valid_cycle", 32'(cyc), 32'(e.due));
                chk("bin_out", 32'(bin_out), 32'(e.bin));
                chk("bin_id", 32'(bin_id), 32'(e.id));
                held_bin = e.bin;
                held_id  = e.id;
            end
        end else begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc)
                chk("missing_valid", 32'(bin_valid), 32'd1);
            chk("bin_out_hold", 32'(bin_out), 32'(held_bin));
            chk("bin_id_hold", 32'(bin_id), 32'(held_id));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        gray0 = WIDTH'($urandom);
        gray1 = WIDTH'($urandom);

        // reset held with both requests asserted
        repeat (3) step();
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;
        step();

        // single request
        gq0.push_back(4'b1011);
        wait_idle(40);

        // contention from a fresh priority pointer
        do_reset(1);
        gq0.push_back(4'b0110);
        gq1.push_back(4'b1111);
        wait_idle(40);

        // exhaustive back-to-back sweep on requester 1
        for (int v = 0; v < 16; v++) gq1.push_back(4'(v));
        wait_idle(200);

        // reset at the second conversion edge
        gq1.push_back(4'b1100);
        begin
            int i;
            i = 0;
            do begin
                step();
                i++;
            end while (!exp_g1 && i < 20);
            chk("mid_rst_grant", 32'(exp_g1), 32'd1);
        end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        gq0.push_back(WIDTH'($urandom));
        gq1.push_back(WIDTH'($urandom));
        wait_idle(40);

        // fairness with both requesters continuously busy
        for (int i = 0; i < 2; i++) begin
            gq0.push_back(WIDTH'($urandom));
            gq1.push_back(WIDTH'($urandom));
        end
        wait_idle(60);

        // randomized traffic with random request gaps
        rnd_gap = 1'b1;
        for (int i = 0; i < 30; i++) begin
            gq0.push_back(WIDTH'($urandom));
            gq1.push_back(WIDTH'($urandom));
        end
        wait_idle(1000);
        repeat (3) step();

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
